ghash_block_packer: RTL and testbench

//  Upstream feeder of the 2-block GHASH stage. Takes one 128-bit AAD/ciphertext block per cycle,

---
 rtl/ghash_block_packer.sv | 173 +++++++++++++++++
 tb/tb_ghash_block_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_block_packer.sv
// GHASH block packer: pads incoming 128-bit AAD/ciphertext blocks, pairs them
// into 256-bit words for the 2-block GHASH stage and appends the GCM length
// block len(A)||len(C) at the end of each packet.
module ghash_block_packer #(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 2,
  parameter int NB_DATA  = N_BLOCKS * NB_BLOCK,
  parameter int NB_LEN   = 64
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [NB_BLOCK-1:0] i_data,
  input  logic                i_valid,
  input  logic                i_is_aad,
  input  logic [4:0]          i_nbytes,
  input  logic                i_last,
  output logic                o_ready,
  output logic [NB_DATA-1:0]  o_data_x_bus,
  output logic [N_BLOCKS-1:0] o_skip_bus,
  output logic                o_sop,
  output logic                o_valid,
  output logic                o_last
);

  localparam int NB_BYTES = NB_BLOCK / 8;

  typedef enum logic {
    ST_ACC,
    ST_LEN
  } state_t;

  state_t                state_q, state_d;
  logic                  slot_full_q, slot_full_d;
  logic [NB_BLOCK-1:0]   slot0_q, slot0_d;
  logic [NB_LEN-1:0]     aad_bits_q, aad_bits_d;
  logic [NB_LEN-1:0]     txt_bits_q, txt_bits_d;
  logic [NB_BLOCK-1:0]   len_q, len_d;
  logic                  sop_pend_q, sop_pend_d;
  logic                  ready_q, ready_d;
  logic [NB_DATA-1:0]    data_q, data_d;
  logic [N_BLOCKS-1:0]   skip_q, skip_d;
  logic                  sop_q, sop_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic [4:0]            nbytes_eff;
  logic [NB_BLOCK-1:0]   blk;
  logic [NB_LEN-1:0]     add_bits;
  logic [NB_LEN-1:0]     aad_sum;
  logic [NB_LEN-1:0]     txt_sum;
  logic [NB_BLOCK-1:0]   len_blk;
  logic                  accept;

  // Next-state logic: padding, length counting, slot pairing and word emission
  always_comb begin
    nbytes_eff = ((i_nbytes == 5'd0) || (i_nbytes > 5'd16)) ? 5'd16 : i_nbytes;

    blk = i_data;
    for (int b = 0; b < NB_BYTES; b++) begin
      if (5'(b) >= nbytes_eff) begin
        blk[NB_BLOCK-1-8*b -: 8] = 8'h00;
      end
    end

    add_bits = {{(NB_LEN-8){1'b0}}, nbytes_eff, 3'b000};
    aad_sum  = aad_bits_q + (i_is_aad ? add_bits : {NB_LEN{1'b0}});
    txt_sum  = txt_bits_q + (i_is_aad ? {NB_LEN{1'b0}} : add_bits);
    len_blk  = {aad_sum, txt_sum};
    accept   = i_valid && ready_q;

    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot0_d     = slot0_q;
    aad_bits_d  = aad_bits_q;
    txt_bits_d  = txt_bits_q;
    len_d       = len_q;
    sop_pend_d  = sop_pend_q;
    data_d      = data_q;
    skip_d      = '0;
    sop_d       = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          aad_bits_d = aad_sum;
          txt_bits_d = txt_sum;
          if (!slot_full_q) begin
            if (i_last) begin
              data_d     = {len_blk, blk};
              valid_d    = 1'b1;
              sop_d      = sop_pend_q;
              last_d     = 1'b1;
              sop_pend_d = 1'b1;
              aad_bits_d = '0;
              txt_bits_d = '0;
            end else begin
              slot0_d     = blk;
              slot_full_d = 1'b1;
            end
          end else begin
            data_d      = {blk, slot0_q};
            valid_d     = 1'b1;
            sop_d       = sop_pend_q;
            sop_pend_d  = 1'b0;
            slot_full_d = 1'b0;
            if (i_last) begin
              len_d      = len_blk;
              aad_bits_d = '0;
              txt_bits_d = '0;
              state_d    = ST_LEN;
            end
          end
        end
      end
      ST_LEN: begin
        data_d     = {{NB_BLOCK{1'b0}}, len_q};
        valid_d    = 1'b1;
        skip_d     = 2'b10;
        last_d     = 1'b1;
        sop_pend_d = 1'b1;
        state_d    = ST_ACC;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    ready_d = (state_d == ST_ACC);
  end

  // State, counters and registered outputs; reset discards any partial packet
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_ACC;
      slot_full_q <= 1'b0;
      slot0_q     <= '0;
      aad_bits_q  <= '0;
      txt_bits_q  <= '0;
      len_q       <= '0;
      sop_pend_q  <= 1'b1;
      ready_q     <= 1'b0;
      data_q      <= '0;
      skip_q      <= '0;
      sop_q       <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot0_q     <= slot0_d;
      aad_bits_q  <= aad_bits_d;
      txt_bits_q  <= txt_bits_d;
      len_q       <= len_d;
      sop_pend_q  <= sop_pend_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      skip_q      <= skip_d;
      sop_q       <= sop_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_data_x_bus = data_q;
  assign o_skip_bus   = skip_q;
  assign o_sop        = sop_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;

endmodule

// File: tb/tb_ghash_block_packer.sv
// Testbench for ghash_block_packer: directed packets with a scoreboard of
// expected output words popped whenever the packer emits a word.
module tb_ghash_block_packer;

  logic         i_clock = 1'b0;
  logic         i_reset_n = 1'b1;
  logic [127:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         i_is_aad = 1'b0;
  logic [4:0]   i_nbytes = 5'd0;
  logic         i_last = 1'b0;
  logic         o_ready;
  logic [255:0] o_data_x_bus;
  logic [1:0]   o_skip_bus;
  logic         o_sop;
  logic         o_valid;
  logic         o_last;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   skip;
    logic         sop;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           rdy_low = 0;
  logic [255:0] prev_data = '0;
  logic         prev_rst_n = 1'b0;

  ghash_block_packer dut (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_is_aad     (i_is_aad),
    .i_nbytes     (i_nbytes),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_data_x_bus (o_data_x_bus),
    .o_skip_bus   (o_skip_bus),
    .o_sop        (o_sop),
    .o_valid      (o_valid),
    .o_last       (o_last)
  );

  always #5 i_clock = ~i_clock;

  // Keep bytes 0..n-1 (byte 0 is the most significant), n outside 1..16 means 16
  function automatic logic [127:0] pad(input logic [127:0] d, input int n);
    int m;
    logic [127:0] keep;
    m = (n < 1 || n > 16) ? 16 : n;
    keep = '1;
    keep = keep << (8 * (16 - m));
    return d & keep;
  endfunction

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_word(input logic [255:0] d, input logic [1:0] s,
                             input logic sop, input logic last);
    exp_t e;
    e.data = d;
    e.skip = s;
    e.sop  = sop;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Present one block and hold it until the packer is ready to take it
  task automatic apply_stimulus(input logic [127:0] d, input logic is_aad,
                                input logic [4:0] nb, input logic last);
    int n;
    @(negedge i_clock);
    i_data   = d;
    i_is_aad = is_aad;
    i_nbytes = nb;
    i_last   = last;
    i_valid  = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    if (n >= 20) check_output("accept_timeout", {255'b0, o_ready}, 256'd1);
  endtask

  task automatic go_idle();
    @(negedge i_clock);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 10) begin
      @(negedge i_clock);
      n++;
    end
    check_output(tag, {255'b0, o_ready}, 256'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    repeat (2) @(negedge i_clock);
    check_output(tag, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic run_test1(input bit idle_after);
    logic [127:0] a0, c0;
    a0 = rnd_block();
    c0 = rnd_block();
    expect_word({c0, a0}, 2'b00, 1'b1, 1'b0);
    expect_word({128'b0, 64'h80, 64'h80}, 2'b10, 1'b0, 1'b1);
    apply_stimulus(a0, 1'b1, 5'd16, 1'b0);
    apply_stimulus(c0, 1'b0, 5'd16, 1'b1);
    if (idle_after) go_idle();
  endtask

  // Scoreboard monitor: compare each emitted word, and idle-cycle invariants
  always @(negedge i_clock) begin
    exp_t e;
    if (i_reset_n && o_ready === 1'b0) rdy_low++;
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_word", {255'b0, o_valid}, 256'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("word_data", o_data_x_bus, e.data);
        check_output("word_skip", {254'b0, o_skip_bus}, {254'b0, e.skip});
        check_output("word_sop", {255'b0, o_sop}, {255'b0, e.sop});
        check_output("word_last", {255'b0, o_last}, {255'b0, e.last});
      end
    end else begin
      check_output("idle_flags", {253'b0, o_skip_bus, o_sop, o_last}, 256'd0);
      if (i_reset_n && prev_rst_n) check_output("idle_hold", o_data_x_bus, prev_data);
    end
    prev_data  = o_data_x_bus;
    prev_rst_n = i_reset_n;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  // Directed test sequence
  initial begin
    logic [127:0] a, c0, c1, c2;

    #1 i_reset_n = 1'b0;
    repeat (2) @(negedge i_clock);
    check_output("reset_ready", {255'b0, o_ready}, 256'd0);
    check_output("reset_valid", {255'b0, o_valid}, 256'd0);
    check_output("reset_data", o_data_x_bus, 256'd0);
    check_output("reset_skip", {254'b0, o_skip_bus}, 256'd0);
    i_reset_n = 1'b1;
    wait_ready("ready_after_reset");

    $display("[TB] test 1: one AAD block then one C block");
    rdy_low = 0;
    run_test1(1'b1);
    drain("t1_drain");
    check_output("t1_ready_low_cycles", 256'(rdy_low), 256'd1);

    $display("[TB] test 2: single 5-byte AAD block, C empty");
    a = rnd_block();
    expect_word({64'h28, 64'h0, pad(a, 5)}, 2'b00, 1'b1, 1'b1);
    apply_stimulus(a, 1'b1, 5'd5, 1'b1);
    go_idle();
    drain("t2_drain");

    $display("[TB] test 3: three C blocks, last one 1 byte");
    c0 = rnd_block();
    c1 = rnd_block();
    c2 = rnd_block();
    expect_word({c1, c0}, 2'b00, 1'b1, 1'b0);
    expect_word({64'h0, 64'h108, pad(c2, 1)}, 2'b00, 1'b0, 1'b1);
    apply_stimulus(c0, 1'b0, 5'd0, 1'b0);
    apply_stimulus(c1, 1'b0, 5'd20, 1'b0);
    apply_stimulus(c2, 1'b0, 5'd1, 1'b1);
    go_idle();
    drain("t3_drain");

    $display("[TB] test 4: reset mid-packet, then test 1 again");
    apply_stimulus(rnd_block(), 1'b1, 5'd16, 1'b0);
    @(negedge i_clock);
    i_valid   = 1'b0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clock);
    check_output("t4_reset_valid", {255'b0, o_valid}, 256'd0);
    check_output("t4_reset_ready", {255'b0, o_ready}, 256'd0);
    i_reset_n = 1'b1;
    wait_ready("t4_ready_after_reset");
    run_test1(1'b1);
    drain("t4_drain");

    $display("[TB] test 5: back-to-back packets");
    run_test1(1'b0);
    a = rnd_block();
    expect_word({64'h28, 64'h0, pad(a, 5)}, 2'b00, 1'b1, 1'b1);
    apply_stimulus(a, 1'b1, 5'd5, 1'b1);
    go_idle();
    drain("t5_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
